stream_integrator: RTL and testbench

Integrate-and-dump stage placed directly downstream of the ±2× stream selector. It consumes the selector's signed output every enabled cycle, accumulates it over a programmable window of N samples with saturation, then presents the window sum, a scaled mean and a saturation flag with a one-cycle valid strobe. It supports single-shot and back-to-back (continuous) windows and is the demodulation/averaging point before the readout logic.

---
 rtl/stream_pkg.sv | 43 ++++
 rtl/stream_integrator_sat_clip.sv | 27 ++
 rtl/stream_integrator.sv | 135 +++++++++++++
 tb/tb_stream_integrator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream path: FSM state encoding and
// signed saturating-add helpers for accumulators up to 62 bits wide.
package stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic               clip;
        logic signed [63:0] sum;
    } sat_res_t;

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 32'd1));
    endfunction

    // Operands must already fit in w bits, so the 64-bit sum cannot wrap.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        sat_res_t          res;
        logic signed [63:0] s;
        s = a + b;
        if (s > sat_max(w)) begin
            res.clip = 1'b1;
            res.sum  = sat_max(w);
        end else if (s < sat_min(w)) begin
            res.clip = 1'b1;
            res.sum  = sat_min(w);
        end else begin
            res.clip = 1'b0;
            res.sum  = s;
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_integrator_sat_clip.sv
// Signed narrowing with clipping to the output range.
module sat_clip #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data
);

    logic [IN_W-OUT_W:0] w_upper;
    logic                w_fits;

    assign w_upper = i_data[IN_W-1:OUT_W-1];
    assign w_fits  = (&w_upper) | (~|w_upper);

    // Pass through when the discarded bits are pure sign extension.
    always_comb begin
        o_data = i_data[OUT_W-1:0];
        if (!w_fits) begin
            o_data = i_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            o_data = i_data[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/stream_integrator.sv
// Integrate-and-dump over a programmable window of enabled samples,
// with saturating accumulation and single-shot or continuous windows.
module stream_integrator
    import stream_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic                        en,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        cont,
    input  logic        [CNT_WIDTH-1:0] window_len,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic signed [WIDTH-1:0]     out_mean,
    output logic                        out_sat,
    output logic                        out_valid,
    output logic                        busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                     r_state;
    state_t                     w_state_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [CNT_WIDTH-1:0] r_cnt;
    logic        [CNT_WIDTH-1:0] r_len;
    logic                        r_cont;
    logic                        r_sat_flag;

    sat_res_t                    w_res;
    logic signed [ACC_WIDTH-1:0] w_sum_sat;
    logic signed [ACC_WIDTH-1:0] w_mean_pre;
    logic signed [WIDTH-1:0]     w_mean;
    logic                        w_start_ok;
    logic                        w_last;

    assign w_res      = sat_add(64'(r_acc), 64'(in_data), ACC_WIDTH);
    assign w_sum_sat  = ACC_WIDTH'(w_res.sum);
    assign w_mean_pre = w_sum_sat >>> SHIFT;
    assign w_start_ok = start && (window_len != CNT_ZERO) && !stop;
    assign w_last     = (r_state == RUN) && en && (r_cnt == (r_len - CNT_ONE));
    assign busy       = (r_state == RUN);

    sat_clip #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (WIDTH)
    ) u_mean_clip (
        .i_data (w_mean_pre),
        .o_data (w_mean)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: stop always wins, continuous windows stay in RUN.
    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = w_start_ok ? RUN : IDLE;
                RUN:     w_state_next = (w_last && !r_cont) ? IDLE : RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Accumulator, counter, latched window config and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= CNT_ZERO;
            r_len      <= CNT_ZERO;
            r_cont     <= 1'b0;
            r_sat_flag <= 1'b0;
            out_sum    <= '0;
            out_mean   <= '0;
            out_sat    <= 1'b0;
            out_valid  <= 1'b0;
        end else if (stop) begin
            r_acc      <= '0;
            r_cnt      <= CNT_ZERO;
            r_cont     <= 1'b0;
            r_sat_flag <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len      <= window_len;
                        r_cont     <= cont;
                        r_acc      <= '0;
                        r_cnt      <= CNT_ZERO;
                        r_sat_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        out_sum    <= w_sum_sat;
                        out_mean   <= w_mean;
                        out_sat    <= r_sat_flag | w_res.clip;
                        out_valid  <= 1'b1;
                        r_acc      <= '0;
                        r_cnt      <= CNT_ZERO;
                        r_sat_flag <= 1'b0;
                    end else if (en) begin
                        r_acc      <= w_sum_sat;
                        r_cnt      <= r_cnt + CNT_ONE;
                        r_sat_flag <= r_sat_flag | w_res.clip;
                    end
                end
                default: begin
                    r_acc <= '0;
                    r_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_integrator.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on out_valid.
module tb_stream_integrator;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] mean;
        logic        sat;
        int          cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in_data = '0;
    logic               en = 1'b0;
    logic               start = 1'b0;
    logic               start18 = 1'b0;
    logic               stop = 1'b0;
    logic               cont = 1'b0;
    logic [15:0]        window_len = '0;

    logic signed [31:0] out_sum;
    logic signed [15:0] out_mean;
    logic               out_sat, out_valid, busy;
    logic signed [17:0] out_sum18;
    logic signed [15:0] out_mean18;
    logic               out_sat18, out_valid18, busy18;

    exp_t q[$];
    exp_t q18[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_integrator dut (
        .clk(clk), .rst(rst), .in_data(in_data), .en(en), .start(start),
        .stop(stop), .cont(cont), .window_len(window_len),
        .out_sum(out_sum), .out_mean(out_mean), .out_sat(out_sat),
        .out_valid(out_valid), .busy(busy)
    );

    stream_integrator #(.WIDTH(16), .ACC_WIDTH(18), .CNT_WIDTH(16), .SHIFT(4)) dut18 (
        .clk(clk), .rst(rst), .in_data(in_data), .en(en), .start(start18),
        .stop(stop), .cont(cont), .window_len(window_len),
        .out_sum(out_sum18), .out_mean(out_mean18), .out_sat(out_sat18),
        .out_valid(out_valid18), .busy(busy18)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Main DUT monitor: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum",  {32'd0, out_sum},  {32'd0, e.sum});
                check("mean", {48'd0, out_mean}, {48'd0, e.mean});
                check("sat",  {63'd0, out_sat},  {63'd0, e.sat});
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Narrow-accumulator DUT monitor.
    always @(negedge clk) begin
        if (out_valid18 === 1'b1) begin
            if (q18.size() == 0) begin
                check("unexpected_valid18", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q18.pop_front();
                check("sum18",  {46'd0, out_sum18},  {32'd0, e.sum});
                check("mean18", {48'd0, out_mean18}, {48'd0, e.mean});
                check("sat18",  {63'd0, out_sat18},  {63'd0, e.sat});
                check("valid_cycle18", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic e, input logic signed [15:0] d);
        en = e;
        in_data = d;
        tick();
    endtask

    task automatic push(input logic [31:0] s, input logic [15:0] m, input logic sat);
        exp_t e;
        e.sum = s; e.mean = m; e.sat = sat; e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic open_win(input logic [15:0] len, input logic c);
        start = 1'b1; window_len = len; cont = c; en = 1'b0;
        tick();
        start = 1'b0; cont = 1'b0;
    endtask

    initial begin
        exp_t e;
        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_sum",   {32'd0, out_sum}, 64'd0);
        check("rst_mean",  {48'd0, out_mean}, 64'd0);
        check("rst_sat",   {63'd0, out_sat}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);

        // Single-shot len=4 of +100
        open_win(16'd4, 1'b0);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 3; i++) smp(1'b1, 16'sd100);
        push(32'd400, 16'd25, 1'b0);
        smp(1'b1, 16'sd100);
        check("busy_drop", {63'd0, busy}, 64'd0);
        smp(1'b0, 16'sd0);

        // Gapped samples, negative sum and arithmetic shift
        open_win(16'd3, 1'b0);
        smp(1'b1, 16'sd10);
        smp(1'b0, 16'sd999);
        smp(1'b1, -16'sd30);
        smp(1'b0, 16'sd999);
        push(32'hFFFF_FFF1, 16'hFFFF, 1'b0);
        smp(1'b1, 16'sd5);
        smp(1'b0, 16'sd0);

        // Saturation on the 18-bit accumulator instance
        start18 = 1'b1; window_len = 16'd16; cont = 1'b0; en = 1'b0;
        tick();
        start18 = 1'b0;
        for (int i = 0; i < 15; i++) smp(1'b1, 16'sd32767);
        e.sum = 32'd131071; e.mean = 16'd8191; e.sat = 1'b1; e.cyc = cyc + 1;
        q18.push_back(e);
        smp(1'b1, 16'sd32767);
        smp(1'b0, 16'sd0);

        // Continuous mode len=2, then stop
        open_win(16'd2, 1'b1);
        smp(1'b1, 16'sd1);
        push(32'd3, 16'd0, 1'b0);
        smp(1'b1, 16'sd2);
        smp(1'b1, 16'sd3);
        push(32'd7, 16'd0, 1'b0);
        smp(1'b1, 16'sd4);
        check("cont_busy", {63'd0, busy}, 64'd1);
        stop = 1'b1;
        smp(1'b1, 16'sd50);
        stop = 1'b0;
        check("stop_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 4; i++) smp(1'b1, 16'sd50);

        // Stop coincident with the last sample suppresses the result
        open_win(16'd4, 1'b0);
        for (int i = 0; i < 3; i++) smp(1'b1, 16'sd50);
        stop = 1'b1;
        smp(1'b1, 16'sd50);
        stop = 1'b0;
        smp(1'b0, 16'sd0);
        check("retained_sum", {32'd0, out_sum}, 64'd7);
        check("stopped_busy", {63'd0, busy}, 64'd0);
        open_win(16'd0, 1'b0);
        check("len0_ignored", {63'd0, busy}, 64'd0);
        smp(1'b1, 16'sd1);
        check("len0_still_idle", {63'd0, busy}, 64'd0);

        // len=1 continuous: every enabled sample dumps
        open_win(16'd1, 1'b1);
        push(32'd9, 16'd0, 1'b0);
        smp(1'b1, 16'sd9);
        smp(1'b0, 16'sd0);
        push(32'hFFFF_FFF7, 16'hFFFF, 1'b0);
        smp(1'b1, -16'sd9);
        stop = 1'b1;
        smp(1'b0, 16'sd0);
        stop = 1'b0;

        // Reset mid-window, then a clean window
        open_win(16'd4, 1'b0);
        smp(1'b1, 16'sd1000);
        smp(1'b1, 16'sd1000);
        rst = 1'b1;
        smp(1'b0, 16'sd0);
        rst = 1'b0;
        check("midrst_sum",   {32'd0, out_sum}, 64'd0);
        check("midrst_mean",  {48'd0, out_mean}, 64'd0);
        check("midrst_sat",   {63'd0, out_sat}, 64'd0);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy",  {63'd0, busy}, 64'd0);
        open_win(16'd4, 1'b0);
        smp(1'b1, 16'sd5);
        smp(1'b1, 16'sd6);
        smp(1'b1, 16'sd7);
        push(32'd26, 16'd1, 1'b0);
        smp(1'b1, 16'sd8);
        smp(1'b0, 16'sd0);
        smp(1'b0, 16'sd0);

        check("q_drained",   64'(q.size()), 64'd0);
        check("q18_drained", 64'(q18.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
